// File: rtl/score_pkg.sv
// ----------------------------------------------------------------------------
// score_pkg
// Shared definitions for the per-user score RAM agents: the score writer,
// the table reader (score_table_reader) and the leaderboard/display logic.
//   NUM_USERS_DEF   : default number of score slots scanned
//   DATA_W_DEF      : default score width
//   USER_W          : width of a user ID (up to 8 users)
//   CNT_W           : width of a played-user count (0..8)
//   SCORE_BASE_ADDR : RAM address of user 0's score slot
//   state_t         : table reader FSM states
// ----------------------------------------------------------------------------
package score_pkg;

   localparam int NUM_USERS_DEF   = 6;
   localparam int DATA_W_DEF      = 8;
   localparam int USER_W          = 3;
   localparam int CNT_W           = 4;
   localparam int SCORE_BASE_ADDR = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_READ,
      ST_DRAIN,
      ST_DONE
   } state_t;

endpackage

// File: rtl/score_table_reader_if.sv
// ----------------------------------------------------------------------------
// score_table_reader_if
// Read-only port onto the shared score RAM, through the RAM arbiter.
//   bus_req : port request (reader -> arbiter)
//   bus_gnt : port grant, may drop at any cycle (arbiter -> reader)
//   rd_addr : read address (reader -> RAM)
//   rd_data : read data, valid the cycle after rd_addr (RAM -> reader)
// master = the reading agent, slave = the arbiter/RAM side.
// ----------------------------------------------------------------------------
interface score_table_reader_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) ();

   logic              bus_req;
   logic              bus_gnt;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;

   modport master (
      output bus_req,
      output rd_addr,
      input  bus_gnt,
      input  rd_data
   );

   modport slave (
      input  bus_req,
      input  rd_addr,
      output bus_gnt,
      output rd_data
   );

endinterface

// File: rtl/score_max_tracker.sv
// ----------------------------------------------------------------------------
// score_max_tracker
// Running maximum / arg-max / nonzero count over a stream of score words.
//   clk      : clock
//   seed     : clear the running values to zero (wins over upd)
//   upd      : fold data/tag into the running values this cycle
//   data     : returned score word
//   tag      : user ID (slot address) the word belongs to
//   max_nxt  : running max including this cycle's word
//   user_nxt : user holding max_nxt
//   cnt_nxt  : nonzero-score count including this cycle's word
// The *_nxt outputs are the values the registers take at the coming edge,
// so the owner can capture the final result on the same edge as the last
// word is folded in.
// ----------------------------------------------------------------------------
module score_max_tracker
   import score_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              seed,
   input  logic              upd,
   input  logic [DATA_W-1:0] data,
   input  logic [USER_W-1:0] tag,
   output logic [DATA_W-1:0] max_nxt,
   output logic [USER_W-1:0] user_nxt,
   output logic [CNT_W-1:0]  cnt_nxt
);

   logic [DATA_W-1:0] max_q,  max_d;
   logic [USER_W-1:0] user_q, user_d;
   logic [CNT_W-1:0]  cnt_q,  cnt_d;

   always_comb begin
      max_d  = max_q;
      user_d = user_q;
      cnt_d  = cnt_q;
      if (seed) begin
         max_d  = '0;
         user_d = '0;
         cnt_d  = '0;
      end else if (upd) begin
         // Strict compare: on a tie the earlier (lower) user ID is kept.
         if (data > max_q) begin
            max_d  = data;
            user_d = tag;
         end
         if (data != '0) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Data registers only: always seeded before the first update of a scan.
   always_ff @(posedge clk) begin
      max_q  <= max_d;
      user_q <= user_d;
      cnt_q  <= cnt_d;
   end

   assign max_nxt  = max_d;
   assign user_nxt = user_d;
   assign cnt_nxt  = cnt_d;

endmodule

// File: rtl/score_table_reader.sv
// ----------------------------------------------------------------------------
// score_table_reader
// On request, acquires the shared score RAM port, sweeps slots
// 0..NUM_USERS-1 in order and publishes the top score, its holder and the
// number of users with a nonzero score.
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   scan_req     : start a scan (sampled in IDLE only)
//   bus          : RAM read port (master side)
//   best_score   : highest score of the last completed scan
//   best_user    : user holding best_score (lowest ID on a tie)
//   played_count : number of slots with a nonzero score
//   busy         : high whenever not IDLE
//   done         : one-cycle pulse when the results update
// A grant loss during READ/DRAIN abandons the partial scan and restarts it
// from slot 0 once the grant returns; published results only change on a
// completed scan.
// ----------------------------------------------------------------------------
module score_table_reader
   import score_pkg::*;
#(
   parameter int NUM_USERS = NUM_USERS_DEF,
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = DATA_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    scan_req,
   score_table_reader_if.master    bus,
   output logic [DATA_W-1:0]       best_score,
   output logic [USER_W-1:0]       best_user,
   output logic [CNT_W-1:0]        played_count,
   output logic                    busy,
   output logic                    done
);

   localparam logic [USER_W-1:0] LAST_ADDR = USER_W'(NUM_USERS - 1);

   state_t            state_q,   state_d;
   logic [USER_W-1:0] addr_q,    addr_d;
   logic              bus_req_q, bus_req_d;
   logic              busy_q,    busy_d;
   logic              done_q,    done_d;
   logic [DATA_W-1:0] best_score_q,   best_score_d;
   logic [USER_W-1:0] best_user_q,    best_user_d;
   logic [CNT_W-1:0]  played_count_q, played_count_d;
   logic              vld_p1_q,  vld_p1_d;
   logic [USER_W-1:0] tag_p1_q,  tag_p1_d;

   logic [DATA_W-1:0] max_nxt;
   logic [USER_W-1:0] user_nxt;
   logic [CNT_W-1:0]  cnt_nxt;

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      vld_p1_d       = 1'b0;
      tag_p1_d       = addr_q;
      best_score_d   = best_score_q;
      best_user_d    = best_user_q;
      played_count_d = played_count_q;
      case (state_q)
         ST_IDLE: begin
            addr_d = '0;
            if (scan_req) state_d = ST_REQ;
         end
         ST_REQ: begin
            addr_d = '0;
            if (bus.bus_gnt) state_d = ST_READ;
         end
         ST_READ: begin
            if (!bus.bus_gnt) begin
               // Address issued this cycle was not granted: abandon the scan.
               state_d = ST_REQ;
               addr_d  = '0;
            end else begin
               vld_p1_d = 1'b1;
               if (addr_q == LAST_ADDR) begin
                  state_d = ST_DRAIN;
                  addr_d  = '0;
               end else begin
                  addr_d = addr_q + USER_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (!bus.bus_gnt) begin
               state_d = ST_REQ;
            end else begin
               // The last word is folded in on this edge; publish the result.
               state_d        = ST_DONE;
               best_score_d   = max_nxt;
               best_user_d    = user_nxt;
               played_count_d = cnt_nxt;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            addr_d  = '0;
         end
      endcase
      bus_req_d = (state_d == ST_REQ) || (state_d == ST_READ) || (state_d == ST_DRAIN);
      busy_d    = (state_d != ST_IDLE);
      done_d    = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         addr_q         <= '0;
         bus_req_q      <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         vld_p1_q       <= 1'b0;
         best_score_q   <= '0;
         best_user_q    <= '0;
         played_count_q <= '0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         bus_req_q      <= bus_req_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         vld_p1_q       <= vld_p1_d;
         best_score_q   <= best_score_d;
         best_user_q    <= best_user_d;
         played_count_q <= played_count_d;
      end
   end

   // Stage p0 -> p1: address tag travels with its valid to meet rd_data.
   always_ff @(posedge clk) begin
      tag_p1_q <= tag_p1_d;
   end

   // Seeded every REQ cycle, so the running values are zero on READ entry
   // and any partial scan abandoned by a grant drop is discarded.
   score_max_tracker #(
      .DATA_W (DATA_W)
   ) u_tracker (
      .clk      (clk),
      .seed     (state_q == ST_REQ),
      .upd      (vld_p1_q),
      .data     (bus.rd_data),
      .tag      (tag_p1_q),
      .max_nxt  (max_nxt),
      .user_nxt (user_nxt),
      .cnt_nxt  (cnt_nxt)
   );

   assign bus.bus_req  = bus_req_q;
   assign bus.rd_addr  = ADDR_W'(SCORE_BASE_ADDR) + ADDR_W'(addr_q);
   assign best_score   = best_score_q;
   assign best_user    = best_user_q;
   assign played_count = played_count_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: tb/tb_score_table_reader.sv
module tb_score_table_reader;
   import score_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       scan_req;
   logic [7:0] best_score;
   logic [2:0] best_user;
   logic [3:0] played_count;
   logic       busy;
   logic       done;

   score_table_reader_if #(.ADDR_W(5), .DATA_W(8)) bus_if ();

   score_table_reader #(
      .NUM_USERS (6),
      .ADDR_W    (5),
      .DATA_W    (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .scan_req     (scan_req),
      .bus          (bus_if),
      .best_score   (best_score),
      .best_user    (best_user),
      .played_count (played_count),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   // Score RAM model: one-cycle read latency.
   logic [7:0] ram [32];
   always @(posedge clk) bus_if.rd_data <= ram[bus_if.rd_addr];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [47:0] pack6(input int a0, input int a1, input int a2,
                                         input int a3, input int a4, input int a5);
      logic [7:0] b0, b1, b2, b3, b4, b5;
      b0 = a0[7:0]; b1 = a1[7:0]; b2 = a2[7:0];
      b3 = a3[7:0]; b4 = a4[7:0]; b5 = a5[7:0];
      return {b5, b4, b3, b2, b1, b0};
   endfunction

   task automatic load_ram(input logic [47:0] r);
      for (int i = 0; i < 32; i++) ram[i] = 8'd0;
      for (int i = 0; i < 6; i++) ram[i] = r[i*8 +: 8];
   endtask

   // Pulse scan_req at cycle 0; grant withheld for 'delay' cycles of bus_req.
   // lat = cycle number at which done is seen (-1 on timeout).
   task automatic run_scan(input int delay, output int lat, output int hold_bad);
      int n;
      int req_cycles;
      @(negedge clk);
      bus_if.bus_gnt = (delay == 0);
      scan_req = 1'b1;
      n = 0; req_cycles = 0; hold_bad = 0; lat = -1;
      while (n < 100 && lat < 0) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         scan_req = 1'b0;
         if (done) lat = n;
         if (bus_if.bus_req) req_cycles++;
         bus_if.bus_gnt = (req_cycles > delay);
         if (!bus_if.bus_gnt && (!bus_if.bus_req || bus_if.rd_addr != 5'd0)) hold_bad++;
      end
   endtask

   typedef struct {
      logic [47:0] ram;
      int          delay;
      int          score;
      int          user;
      int          cnt;
      int          lat;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int lat, hold_bad, n, dropped, cnt_bad;
      int pos [$];

      vecs[0] = '{pack6(10, 45, 3, 45, 0, 7),    0, 45,  1, 5, 9};
      vecs[1] = '{pack6(0, 0, 0, 0, 0, 0),       0, 0,   0, 0, 9};
      vecs[2] = '{pack6(1, 2, 3, 4, 5, 6),       4, 6,   5, 6, 13};
      vecs[3] = '{pack6(200, 200, 0, 0, 0, 199), 0, 200, 0, 3, 9};
      vecs[4] = '{pack6(0, 0, 0, 0, 0, 255),     1, 255, 5, 1, 10};
      vecs[5] = '{pack6(10, 45, 3, 45, 0, 7),    0, 45,  1, 5, 9};

      rst = 1'b1;
      scan_req = 1'b0;
      bus_if.bus_gnt = 1'b0;
      load_ram(pack6(0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst0_score",   best_score,     0);
      chk("rst0_user",    best_user,      0);
      chk("rst0_count",   played_count,   0);
      chk("rst0_busy",    busy,           0);
      chk("rst0_done",    done,           0);
      chk("rst0_bus_req", bus_if.bus_req, 0);
      chk("rst0_rd_addr", bus_if.rd_addr, 0);

      for (int i = 0; i < 6; i++) begin
         load_ram(vecs[i].ram);
         run_scan(vecs[i].delay, lat, hold_bad);
         chk($sformatf("v%0d_latency", i), lat,          vecs[i].lat);
         chk($sformatf("v%0d_score", i),   best_score,   vecs[i].score);
         chk($sformatf("v%0d_user", i),    best_user,    vecs[i].user);
         chk($sformatf("v%0d_count", i),   played_count, vecs[i].cnt);
         chk($sformatf("v%0d_gnt_hold", i), hold_bad,    0);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("v%0d_done_pulse", i), done, 0);
         chk($sformatf("v%0d_idle_busy", i),  busy, 0);
      end

      // Grant dropped for one cycle while slot 3 is being read.
      load_ram(pack6(0, 0, 0, 0, 0, 200));
      @(negedge clk);
      bus_if.bus_gnt = 1'b1;
      scan_req = 1'b1;
      n = 0; lat = -1; dropped = 0; hold_bad = 0;
      while (n < 100 && lat < 0) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         scan_req = 1'b0;
         if (done) lat = n;
         else if (best_score != 8'd45 || best_user != 3'd1 || played_count != 4'd5) hold_bad++;
         if (bus_if.rd_addr == 5'd3 && dropped == 0) begin
            bus_if.bus_gnt = 1'b0;
            dropped = 1;
         end else begin
            bus_if.bus_gnt = 1'b1;
         end
      end
      chk("gd_dropped",  dropped,      1);
      chk("gd_latency",  lat,          14);
      chk("gd_held_old", hold_bad,     0);
      chk("gd_score",    best_score,   200);
      chk("gd_user",     best_user,    5);
      chk("gd_count",    played_count, 1);

      // scan_req held high: back-to-back scans, one done each.
      load_ram(pack6(10, 45, 3, 45, 0, 7));
      @(negedge clk);
      bus_if.bus_gnt = 1'b1;
      scan_req = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) pos.push_back(c);
      end
      scan_req = 1'b0;
      chk("hold_done_count", pos.size(), 4);
      for (int k = 0; k < pos.size(); k++)
         chk($sformatf("hold_done%0d_cycle", k), pos[k], 9 + 10 * k);
      chk("hold_score", best_score,   45);
      chk("hold_user",  best_user,    1);
      chk("hold_count", played_count, 5);
      @(posedge clk);
      @(negedge clk);
      chk("hold_idle_busy", busy, 0);

      // Reset asserted for two cycles in the middle of READ.
      @(negedge clk);
      scan_req = 1'b1;
      n = 0;
      while (n < 20 && bus_if.rd_addr != 5'd2) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         scan_req = 1'b0;
      end
      chk("mid_rst_reached_read", bus_if.rd_addr, 2);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_score",   best_score,     0);
      chk("mid_rst_user",    best_user,      0);
      chk("mid_rst_count",   played_count,   0);
      chk("mid_rst_busy",    busy,           0);
      chk("mid_rst_done",    done,           0);
      chk("mid_rst_bus_req", bus_if.bus_req, 0);
      chk("mid_rst_rd_addr", bus_if.rd_addr, 0);
      chk("mid_rst_state",   int'(dut.state_q == ST_IDLE), 1);
      cnt_bad = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (busy || done || bus_if.bus_req) cnt_bad++;
      end
      chk("mid_rst_stays_idle", cnt_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/score_table_reader.md
# score_table_reader

Read-side companion to the per-user score RAM. On request it acquires the shared RAM port, sweeps the user score slots in address order, and publishes the top score, the user who holds it, and how many users have a nonzero score. It sits between the score RAM arbiter and the leaderboard / seven-segment display logic.

## Interface

- NUM_USERS, 6: score slots scanned, addresses 0..NUM_USERS-1; legal range 1..8.
- ADDR_W, 5: RAM address width.
- DATA_W, 8: score width.
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- scan_req  in  1  start a scan; sampled only in IDLE; level or pulse.
- bus_gnt  in  1  RAM port grant from the arbiter; may drop at any cycle.
- rd_data  in  DATA_W  RAM read data, valid the cycle after rd_addr is presented.
- bus_req  out  1  RAM port request.
- rd_addr  out  ADDR_W  RAM read address; bits above bit 2 always 0.
- best_score  out  DATA_W  highest score from the last completed scan.
- best_user  out  3  user ID holding best_score.
- played_count  out  4  number of slots with a nonzero score.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the results update.

## Operation

- States: IDLE, REQ, READ, DRAIN, DONE.
- IDLE: bus_req=0. scan_req=1 moves to REQ.
- REQ: bus_req=1, rd_addr=0. If bus_gnt=1, move to READ.
- READ: bus_req=1. rd_addr starts at 0 and increments by 1 each cycle. After NUM_USERS-1 is issued, move to DRAIN.
- DRAIN: bus_req=1. The last read word is consumed. Move to DONE.
- DONE: bus_req=0, done=1. Move to IDLE.
- Compare pipeline: a 1-cycle valid flag and address tag follow each issued address. A running max, user and count are seeded at zero when READ is entered.
- Each returned word w at tag k:
  - if w > running max, then max=w and user=k. The comparison is strict, so on a tie the lower user ID wins.
  - if w != 0, count increments.
- best_score, best_user and played_count load from the running values on the edge entering DONE. They hold otherwise, including across aborted scans.
- Grant loss: if bus_gnt=0 in READ or DRAIN, the scan aborts, the running values are discarded, and the state returns to REQ. The scan restarts from address 0 on regrant.
- scan_req while busy is ignored. No queuing.
- All-zero table gives best_score=0, best_user=0, played_count=0.
- No writes are ever issued. The block is read-only.

## Timing

- Reset (rst=1 at an edge): state IDLE. bus_req=0, rd_addr=0, best_score=0, best_user=0, played_count=0, busy=0, done=0. This applies from the next cycle. Reset mid-scan discards everything.
- Latency with grant held high, scan_req sampled at cycle T:
  - REQ at T+1.
  - READ at T+2..T+1+NUM_USERS.
  - DRAIN at T+2+NUM_USERS.
  - DONE/done at T+3+NUM_USERS. For NUM_USERS=6 this is T+9.
- Each cycle bus_gnt is low in REQ adds one cycle.
- A grant drop costs the partial scan plus a full restart.
- done is never asserted two cycles in a row. Minimum spacing between scans is NUM_USERS+4 cycles.
- rd_data is sampled only in the cycle after an issued address. It is ignored in IDLE and REQ.

## Structure

- Shared package `score_pkg`:
  - state enum,
  - NUM_USERS and DATA_W defaults,
  - USER_W=3,
  - the score-slot base address (0).
- The package is shared with the score writer and the display logic.
- One natural sub-module, `score_max_tracker`: the running max/user/count registers with seed, update and compare logic.
- The FSM, address counter and valid/tag pipeline stay in the top.

## Test plan

- Reset: assert rst for 2 cycles mid-READ. Next cycle all outputs are 0, state is IDLE and bus_req is 0.
- Normal scan: RAM = {10,45,3,45,0,7}, bus_gnt tied 1, scan_req pulse at T. Expect done only at T+9 with best_score=45, best_user=1 and played_count=5.
- Empty table: all slots 0. Expect done with best_score=0, best_user=0 and played_count=0. Previous results are overwritten.
- Delayed grant: bus_gnt held 0 for 4 cycles after bus_req rises. Expect rd_addr held at 0, bus_req held high, and done at T+13.
- Grant drop: RAM = {0,0,0,0,0,200}. Prior results are 45/1/5. Drop bus_gnt for 1 cycle while rd_addr=3. Expect:
  - outputs stay 45/1/5 until the restarted scan completes,
  - then best_score=200, best_user=5, played_count=1.
- Busy scan_req: hold scan_req high throughout a scan. Expect exactly one done per scan, with back-to-back scans spaced 10 cycles apart.
